regfile_mp_bypass: RTL and testbench
====================================

Name: regfile_mp_bypass

Overview:
Parametrised register file for the pipelined MIPS datapath. It has NUM_RD combinational read ports, one synchronous write port, and same-cycle write-to-read bypass, so the negedge write trick is no longer needed. It also holds a per-register busy scoreboard. Decode reserves a destination, writeback clears it, and the scoreboard flags RAW hazards per read port.

Parameters:
DATA_W, 32, register data width in bits
ADDR_W, 5, register address width; depth = 2**ADDR_W
NUM_RD, 2, number of independent read ports (1..4)
ZERO_REG, 1, when 1, register 0 is hardwired to zero and never busy
BYPASS, 1, when 1, a write in the current cycle is visible on read ports in the same cycle

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-high
rd_addr  input  NUM_RD*ADDR_W  read addresses; port k uses bits [k*ADDR_W +: ADDR_W]
rd_data  output  NUM_RD*DATA_W  read data, port k at [k*DATA_W +: DATA_W]
rd_busy  output  NUM_RD  port k address has an outstanding reservation
wr_en  input  1  write enable
wr_addr  input  ADDR_W  write address
wr_data  input  DATA_W  write data
resv_en  input  1  reserve destination (issue)
resv_addr  input  ADDR_W  register to mark busy
flush  input  1  synchronous clear of all busy bits (pipeline flush)
busy_cnt  output  ADDR_W+1  number of registers currently busy

Behaviour:
- Reset (async, rst=1):
  - all registers are 0, all busy bits are 0, busy_cnt=0.
  - rd_data reflects the zeroed array; rd_busy=0.
  - Applies immediately, including mid-operation; writes, reserves and flush are ignored while rst is high.
- Write, on posedge clk:
  - if wr_en && !(ZERO_REG && wr_addr==0), then mem[wr_addr] <= wr_data.
  - Write latency is 1 cycle to the array.
- Read (combinational, 0 latency), for each port k:
  - if ZERO_REG && rd_addr_k==0, rd_data_k=0.
  - else if BYPASS && wr_en && wr_addr==rd_addr_k (and wr_addr legal per ZERO_REG), rd_data_k=wr_data.
  - else rd_data_k=mem[rd_addr_k].
  - With BYPASS=0, a write becomes visible on the cycle after the write edge.
- Scoreboard busy[i], updated on posedge clk, in priority order:
  1. flush=1: all busy <= 0. Reservation and write-clear are ignored that cycle; the data write still occurs.
  2. resv_en && resv_addr==wr_addr && wr_en: busy[resv_addr] <= 1. The new producer wins; the data is still written.
  3. otherwise resv_en sets busy[resv_addr] <= 1, and wr_en clears busy[wr_addr] <= 0, independently.
- Scoreboard details:
  - Reserving an already-busy register leaves it busy (no counting of multiple producers).
  - With ZERO_REG=1, reservation of address 0 is ignored; busy[0] is always 0.
  - A write to a non-busy register is legal and leaves it non-busy.
- rd_busy_k:
  - equals busy[rd_addr_k], except it is forced to 0 when BYPASS=1 and the same cycle's wr_en/wr_addr matches rd_addr_k with no reservation of that address in the same cycle.
  - It is combinational.
- busy_cnt:
  - registered population count of busy, updated the same edge as busy.
  - Range 0..2**ADDR_W (or 2**ADDR_W-1 with ZERO_REG).
  - It is a true popcount and cannot overflow.
- Width rules:
  - addresses are unsigned, with no wrap or truncation inside the block.
  - wr_data is stored unmodified at DATA_W bits.

Test Plan:
- Reset clears the array: write 0xDEADBEEF to r5, assert rst asynchronously mid-cycle → rd_data for r5 = 0 immediately, busy_cnt=0, rd_busy=0.
- Bypass: wr_en=1, wr_addr=7, wr_data=0x12345678, rd_addr port0=7 in the same cycle → rd_data0=0x12345678 before the edge. With BYPASS=0 the old value is returned until after the edge.
- Zero register: write 0xFFFFFFFF to r0 and reserve r0 → rd_data=0, rd_busy=0, busy_cnt unchanged.
- Scoreboard: reserve r3 → the next cycle shows rd_busy=1 on a port reading r3 and busy_cnt=1. Write r3=0x55 → the next cycle shows rd_busy=0, busy_cnt=0, rd_data=0x55.
- Simultaneous reserve and write of r9 → r9 holds the written data and busy[r9]=1. Reserve r4 and write r6 together → r4 busy, r6 clear.
- Flush: reserve r1, r2 and r31 over 3 cycles (busy_cnt=3), then flush=1 with resv_en on r8 → all busy=0, busy_cnt=0, r8 not busy. Also check NUM_RD=4 with all ports reading distinct registers.

Source files
------------

// File: rtl/regfile_mp_bypass.sv
// Multi-read-port register file with same-cycle write bypass
// and a per-register busy scoreboard for RAW hazard detection.
//
// Ports:
//   clk, rst         clock (rising edge), async active-high reset
//   rd_addr/rd_data  NUM_RD packed read ports (combinational)
//   rd_busy          per read port: address has an outstanding reservation
//   wr_en/addr/data  single synchronous write port
//   resv_en/addr     reserve a destination register (mark busy)
//   flush            synchronous clear of every busy bit
//   busy_cnt         registered count of busy registers
module regfile_mp_bypass #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     resv_en,
    input  logic [ADDR_W-1:0]        resv_addr,
    input  logic                     flush,
    output logic [ADDR_W:0]          busy_cnt
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DEPTH-1:0]  r_busy;
    logic [DEPTH-1:0]  w_busy_nxt;
    logic [ADDR_W:0]   r_cnt;
    logic [ADDR_W:0]   w_cnt_nxt;
    logic              w_wr_ok;
    logic              w_resv_ok;

    // Register 0 swallows writes and reservations when hardwired.
    assign w_wr_ok   = wr_en && !(ZERO_REG != 0 && wr_addr == '0);
    assign w_resv_ok = resv_en && !(ZERO_REG != 0 && resv_addr == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wr_ok) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    // Clear first, then set: a same-address reserve beats the
    // writeback clear because the new producer is still in flight.
    always_comb begin
        w_busy_nxt = r_busy;
        if (flush) begin
            w_busy_nxt = '0;
        end else begin
            if (w_wr_ok) begin
                w_busy_nxt[wr_addr] = 1'b0;
            end
            if (w_resv_ok) begin
                w_busy_nxt[resv_addr] = 1'b1;
            end
        end
    end

    always_comb begin
        w_cnt_nxt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_cnt_nxt = w_cnt_nxt + {{ADDR_W{1'b0}}, w_busy_nxt[i]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy <= '0;
            r_cnt  <= '0;
        end else begin
            r_busy <= w_busy_nxt;
            r_cnt  <= w_cnt_nxt;
        end
    end

    assign busy_cnt = r_cnt;

    for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
        logic [ADDR_W-1:0] w_ra;
        logic              w_zero;
        logic              w_hit;
        logic              w_resv_same;

        assign w_ra        = rd_addr[g*ADDR_W +: ADDR_W];
        assign w_zero      = (ZERO_REG != 0) && (w_ra == '0);
        // Bypass is suppressed in reset so reads show the cleared array.
        assign w_hit       = (BYPASS != 0) && !rst && w_wr_ok
                             && (wr_addr == w_ra);
        assign w_resv_same = resv_en && (resv_addr == w_ra);

        assign rd_data[g*DATA_W +: DATA_W] =
            w_zero ? '0 : (w_hit ? wr_data : r_mem[w_ra]);

        // A writeback landing this cycle resolves the hazard early,
        // unless a new producer claims the same register right now.
        assign rd_busy[g] = r_busy[w_ra] && !(w_hit && !w_resv_same);
    end

endmodule

// File: tb/tb_regfile_mp_bypass.sv
// Directed self-checking bench for regfile_mp_bypass.
// Main instance: 4 read ports with bypass; side instance: no bypass.
module tb_regfile_mp_bypass;

    localparam int DW = 32;
    localparam int AW = 5;

    logic            clk = 1'b0;
    logic            rst;
    logic [4*AW-1:0] rd_addr;
    logic [4*DW-1:0] rd_data;
    logic [3:0]      rd_busy;
    logic            wr_en;
    logic [AW-1:0]   wr_addr;
    logic [DW-1:0]   wr_data;
    logic            resv_en;
    logic [AW-1:0]   resv_addr;
    logic            flush;
    logic [AW:0]     busy_cnt;

    logic [DW-1:0]   nb_rd_data;
    logic [0:0]      nb_rd_busy;
    logic [AW:0]     nb_busy_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    regfile_mp_bypass #(
        .DATA_W(DW), .ADDR_W(AW), .NUM_RD(4),
        .ZERO_REG(1), .BYPASS(1)
    ) u_dut (
        .clk(clk), .rst(rst),
        .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .resv_en(resv_en), .resv_addr(resv_addr),
        .flush(flush), .busy_cnt(busy_cnt)
    );

    regfile_mp_bypass #(
        .DATA_W(DW), .ADDR_W(AW), .NUM_RD(1),
        .ZERO_REG(1), .BYPASS(0)
    ) u_nb (
        .clk(clk), .rst(rst),
        .rd_addr(rd_addr[AW-1:0]), .rd_data(nb_rd_data),
        .rd_busy(nb_rd_busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .resv_en(resv_en), .resv_addr(resv_addr),
        .flush(flush), .busy_cnt(nb_busy_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        wr_en   = 1'b0;
        resv_en = 1'b0;
        flush   = 1'b0;
    endtask

    task automatic setrd(input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                         input logic [AW-1:0] a2, input logic [AW-1:0] a3);
        rd_addr = {a3, a2, a1, a0};
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
    endtask

    task automatic rsv(input logic [AW-1:0] a);
        resv_en   = 1'b1;
        resv_addr = a;
    endtask

    initial begin
        rst       = 1'b1;
        idle();
        wr_addr   = '0;
        wr_data   = '0;
        resv_addr = '0;
        setrd(5'd0, 5'd0, 5'd0, 5'd0);
        #12;
        rst = 1'b0;
        #1;
        chk("reset_cnt", 64'(busy_cnt), 64'd0);
        chk("reset_busy", 64'(rd_busy), 64'd0);

        // write r5 and reserve r10, then async reset mid-cycle
        wr(5'd5, 32'hDEADBEEF);
        rsv(5'd10);
        tick();
        idle();
        setrd(5'd5, 5'd10, 5'd0, 5'd0);
        #1;
        chk("pre_rst_r5", 64'(rd_data[31:0]), 64'hDEADBEEF);
        chk("pre_rst_cnt", 64'(busy_cnt), 64'd1);
        chk("pre_rst_busy", 64'(rd_busy[1]), 64'd1);
        #1 rst = 1'b1;
        #1;
        chk("rst_r5", 64'(rd_data[31:0]), 64'd0);
        chk("rst_cnt", 64'(busy_cnt), 64'd0);
        chk("rst_busy", 64'(rd_busy), 64'd0);
        #1 rst = 1'b0;

        // bypass vs no bypass
        tick();
        wr(5'd7, 32'h12345678);
        setrd(5'd7, 5'd0, 5'd0, 5'd0);
        #2;
        chk("byp_same_cyc", 64'(rd_data[31:0]), 64'h12345678);
        chk("nobyp_same_cyc", 64'(nb_rd_data), 64'd0);
        tick();
        idle();
        #1;
        chk("nobyp_next", 64'(nb_rd_data), 64'h12345678);
        chk("byp_next", 64'(rd_data[31:0]), 64'h12345678);

        // zero register
        wr(5'd0, 32'hFFFFFFFF);
        rsv(5'd0);
        setrd(5'd0, 5'd0, 5'd0, 5'd0);
        #2;
        chk("r0_data_byp", 64'(rd_data[31:0]), 64'd0);
        chk("r0_busy_byp", 64'(rd_busy[0]), 64'd0);
        tick();
        idle();
        #1;
        chk("r0_data", 64'(rd_data[31:0]), 64'd0);
        chk("r0_busy", 64'(rd_busy[0]), 64'd0);
        chk("r0_cnt", 64'(busy_cnt), 64'd0);

        // reserve r3, then writeback clears it
        rsv(5'd3);
        tick();
        idle();
        setrd(5'd0, 5'd3, 5'd0, 5'd0);
        #1;
        chk("r3_busy", 64'(rd_busy[1]), 64'd1);
        chk("r3_cnt", 64'(busy_cnt), 64'd1);
        wr(5'd3, 32'h55);
        #1;
        chk("r3_wb_fwd_busy", 64'(rd_busy[1]), 64'd0);
        chk("r3_wb_fwd_data", 64'(rd_data[63:32]), 64'h55);
        tick();
        idle();
        #1;
        chk("r3_clr_busy", 64'(rd_busy[1]), 64'd0);
        chk("r3_clr_cnt", 64'(busy_cnt), 64'd0);
        chk("r3_data", 64'(rd_data[63:32]), 64'h55);

        // simultaneous reserve and write of r9
        wr(5'd9, 32'hA5A5);
        rsv(5'd9);
        setrd(5'd0, 5'd0, 5'd9, 5'd0);
        tick();
        idle();
        #1;
        chk("r9_data", 64'(rd_data[95:64]), 64'hA5A5);
        chk("r9_busy", 64'(rd_busy[2]), 64'd1);
        chk("r9_cnt", 64'(busy_cnt), 64'd1);

        // reserve r6, then reserve r4 with r6 writeback
        rsv(5'd6);
        tick();
        idle();
        #1;
        chk("r6_cnt", 64'(busy_cnt), 64'd2);
        rsv(5'd4);
        wr(5'd6, 32'h66);
        setrd(5'd4, 5'd6, 5'd9, 5'd0);
        #1;
        chk("r4r6_pre_busy", 64'(rd_busy), 64'b0100);
        tick();
        idle();
        #1;
        chk("r4r6_busy", 64'(rd_busy), 64'b0101);
        chk("r4r6_cnt", 64'(busy_cnt), 64'd2);
        chk("r6_data", 64'(rd_data[63:32]), 64'h66);

        // flush, then rebuild 3 reservations and flush again
        flush = 1'b1;
        tick();
        idle();
        #1;
        chk("flush0_cnt", 64'(busy_cnt), 64'd0);
        rsv(5'd1);
        tick();
        rsv(5'd2);
        tick();
        rsv(5'd31);
        tick();
        idle();
        setrd(5'd8, 5'd1, 5'd2, 5'd31);
        #1;
        chk("resv3_cnt", 64'(busy_cnt), 64'd3);
        chk("resv3_busy", 64'(rd_busy), 64'b1110);
        flush = 1'b1;
        rsv(5'd8);
        wr(5'd1, 32'h11);
        tick();
        idle();
        #1;
        chk("flush_cnt", 64'(busy_cnt), 64'd0);
        chk("flush_busy", 64'(rd_busy), 64'd0);
        chk("flush_wr_r1", 64'(rd_data[63:32]), 64'h11);
        chk("flush_nb_cnt", 64'(nb_busy_cnt), 64'd0);

        // four ports, distinct registers
        setrd(5'd7, 5'd3, 5'd9, 5'd6);
        #1;
        chk("p0_r7", 64'(rd_data[31:0]), 64'h12345678);
        chk("p1_r3", 64'(rd_data[63:32]), 64'h55);
        chk("p2_r9", 64'(rd_data[95:64]), 64'hA5A5);
        chk("p3_r6", 64'(rd_data[127:96]), 64'h66);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
